// File: rtl/sysa_mm3.sv
// rtl/sysa_mm3.sv - 3x3 weight-stationary systolic array, 8-bit unsigned operands, 16-bit results
//
// Computes Y = X*W for one packed input vector per enabled cycle.
// Column c result Yc = sum_k Xk*W[k][c], truncated to 16 bits.
//
// Ports:
//   clk    - clock, all state on the rising edge
//   rst_n  - synchronous active-low reset, priority over en
//   en     - pipeline advance enable; en=0 freezes every register
//   w      - weights, W[k][c] = w[(k*3+c)*8 +: 8], read combinationally (not latched)
//   in     - input vector, Xk = in[k*8 +: 8], presented unskewed
//   out1   - Y0, valid after enabled edge t+3 for X sampled at edge t
//   out2   - Y1, valid after enabled edge t+4
//   out3   - Y2, valid after enabled edge t+5
module sysa_mm3 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [71:0] w,
    input  logic [23:0] in,
    output logic [15:0] out1,
    output logic [15:0] out2,
    output logic [15:0] out3
);

    localparam int DW = 8;
    localparam int OW = 16;
    localparam int N  = 3;

    // Row k enters the array through k+1 registers: one input register
    // shared by all rows plus k skew stages, so the wavefront reaches
    // PE[k][0] exactly k cycles after PE[0][0].
    logic [DW-1:0]            sk0_q;
    logic [1:0][DW-1:0]       sk1_q;
    logic [2:0][DW-1:0]       sk2_q;

    // Data registers pass operands rightwards. The last column has no
    // consumer to its right, so only columns 0..N-2 carry one.
    logic [N-1:0][N-2:0][DW-1:0] data_q;

    // Partial sums pass downwards; the bottom row is the registered output.
    logic [N-1:0][N-1:0][OW-1:0] psum_q;
    logic [N-1:0][N-1:0][OW-1:0] psum_d;

    logic [N-1:0][DW-1:0]        row_x;
    logic [N-1:0][N-1:0][DW-1:0] pe_x;
    logic [N-1:0][N-1:0][OW-1:0] prod;

    always_comb begin
        row_x[0] = sk0_q;
        row_x[1] = sk1_q[1];
        row_x[2] = sk2_q[2];

        pe_x   = '0;
        prod   = '0;
        psum_d = '0;

        for (int k = 0; k < N; k++) begin
            pe_x[k][0] = row_x[k];
            for (int c = 1; c < N; c++) begin
                pe_x[k][c] = data_q[k][c-1];
            end
        end

        // Products fit in 16 bits; accumulation wraps modulo 2^16.
        for (int k = 0; k < N; k++) begin
            for (int c = 0; c < N; c++) begin
                prod[k][c] = {{(OW-DW){1'b0}}, pe_x[k][c]} *
                             {{(OW-DW){1'b0}}, w[(k*N+c)*DW +: DW]};
            end
        end

        for (int c = 0; c < N; c++) begin
            psum_d[0][c] = prod[0][c];
            for (int k = 1; k < N; k++) begin
                psum_d[k][c] = psum_q[k-1][c] + prod[k][c];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sk0_q  <= '0;
            sk1_q  <= '0;
            sk2_q  <= '0;
            data_q <= '0;
            psum_q <= '0;
        end else if (en) begin
            sk0_q  <= in[7:0];
            sk1_q  <= {sk1_q[0], in[15:8]};
            sk2_q  <= {sk2_q[1:0], in[23:16]};
            for (int k = 0; k < N; k++) begin
                for (int c = 0; c < N-1; c++) begin
                    data_q[k][c] <= pe_x[k][c];
                end
            end
            psum_q <= psum_d;
        end
    end

    assign out1 = psum_q[N-1][0];
    assign out2 = psum_q[N-1][1];
    assign out3 = psum_q[N-1][2];

endmodule

// File: tb/tb_sysa_mm3.sv
// tb/tb_sysa_mm3.sv - self-checking bench for sysa_mm3 with delay-queue reference model
module tb_sysa_mm3;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [71:0] w;
    logic [23:0] in_v;
    logic [15:0] out1;
    logic [15:0] out2;
    logic [15:0] out3;

    int n_checks;
    int n_fail;

    // Reference: each column result is the vector-matrix product of the
    // vector sampled 3/4/5 enabled edges ago (zero when none since reset).
    logic [15:0] h0 [6];
    logic [15:0] h1 [6];
    logic [15:0] h2 [6];

    sysa_mm3 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .w     (w),
        .in    (in_v),
        .out1  (out1),
        .out2  (out2),
        .out3  (out3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] ycol(input logic [71:0] ww, input logic [23:0] x, input int c);
        int s;
        s = 0;
        for (int k = 0; k < 3; k++) begin
            s += int'(x[k*8 +: 8]) * int'(ww[(k*3+c)*8 +: 8]);
        end
        return s[15:0];
    endfunction

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step();
        if (!rst_n) begin
            for (int i = 0; i < 6; i++) begin
                h0[i] = '0;
                h1[i] = '0;
                h2[i] = '0;
            end
        end else if (en) begin
            for (int i = 5; i > 0; i--) begin
                h0[i] = h0[i-1];
                h1[i] = h1[i-1];
                h2[i] = h2[i-1];
            end
            h0[0] = ycol(w, in_v, 0);
            h1[0] = ycol(w, in_v, 1);
            h2[0] = ycol(w, in_v, 2);
        end
    endtask

    // Apply one cycle of stimulus, advance one edge, update model, compare.
    task automatic run(input logic [23:0] x, input logic e, input logic rn);
        in_v  = x;
        en    = e;
        rst_n = rn;
        @(posedge clk);
        #1;
        model_step();
        check_eq("mdl_out1", out1, h0[3]);
        check_eq("mdl_out2", out2, h1[4]);
        check_eq("mdl_out3", out3, h2[5]);
    endtask

    task automatic set_stream_w();
        for (int k = 0; k < 3; k++) begin
            for (int c = 0; c < 3; c++) begin
                w[(k*3+c)*8 +: 8] = 8'(k + c + 1);
            end
        end
    endtask

    logic [95:0] rnd96;
    logic [31:0] rnd32;
    logic        re;
    logic        rr;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < 6; i++) begin
            h0[i] = '0;
            h1[i] = '0;
            h2[i] = '0;
        end
        rnd96 = {$urandom(), $urandom(), $urandom()};
        w     = rnd96[71:0];
        rnd32 = $urandom();
        in_v  = rnd32[23:0];
        en    = 1'b1;
        rst_n = 1'b0;

        // Reset with en=1 and arbitrary data
        for (int i = 0; i < 2; i++) begin
            rnd32 = $urandom();
            run(rnd32[23:0], 1'b1, 1'b0);
        end
        check_eq("rst_out1", out1, 16'h0);
        check_eq("rst_out2", out2, 16'h0);
        check_eq("rst_out3", out3, 16'h0);
        for (int i = 0; i < 3; i++) begin
            run(24'h0, 1'b1, 1'b1);
            check_eq("post_rst_out1", out1, 16'h0);
            check_eq("post_rst_out3", out3, 16'h0);
        end

        // Identity weights, single beat
        w = 72'h01_0000_0001_0000_0001;
        run(24'h030201, 1'b1, 1'b1);
        for (int i = 1; i <= 6; i++) begin
            run(24'h0, 1'b1, 1'b1);
            check_eq("id_out1", out1, (i == 3) ? 16'd1 : 16'd0);
            check_eq("id_out2", out2, (i == 4) ? 16'd2 : 16'd0);
            check_eq("id_out3", out3, (i == 5) ? 16'd3 : 16'd0);
        end

        // Overflow: 3*255*255 mod 2^16
        w = {72{1'b1}};
        run(24'hFFFFFF, 1'b1, 1'b1);
        for (int i = 1; i <= 6; i++) begin
            run(24'h0, 1'b1, 1'b1);
            check_eq("ovf_out1", out1, (i == 3) ? 16'hFA03 : 16'd0);
            check_eq("ovf_out2", out2, (i == 4) ? 16'hFA03 : 16'd0);
            check_eq("ovf_out3", out3, (i == 5) ? 16'hFA03 : 16'd0);
        end

        // Streaming, back-to-back beats
        set_stream_w();
        run(24'h030201, 1'b1, 1'b1);
        run(24'h060504, 1'b1, 1'b1);
        for (int j = 2; j <= 7; j++) begin
            run(24'h0, 1'b1, 1'b1);
            check_eq("str_out1", out1, (j == 3) ? 16'd14 : (j == 4) ? 16'd32 : 16'd0);
            check_eq("str_out2", out2, (j == 4) ? 16'd20 : (j == 5) ? 16'd47 : 16'd0);
            check_eq("str_out3", out3, (j == 5) ? 16'd26 : (j == 6) ? 16'd62 : 16'd0);
        end

        // Stall of 4 cycles right after the beat
        w = 72'h01_0000_0001_0000_0001;
        run(24'h030201, 1'b1, 1'b1);
        for (int i = 1; i <= 10; i++) begin
            run(24'hFFFFFF & {24{i > 4}} & 24'h0, (i > 4), 1'b1);
            check_eq("stall_out1", out1, (i == 7) ? 16'd1 : 16'd0);
            check_eq("stall_out2", out2, (i == 8) ? 16'd2 : 16'd0);
            check_eq("stall_out3", out3, (i == 9) ? 16'd3 : 16'd0);
        end

        // Mid-stream reset discards in-flight vectors
        set_stream_w();
        run(24'h030201, 1'b1, 1'b1);
        run(24'h060504, 1'b1, 1'b1);
        run(24'h0, 1'b1, 1'b0);
        check_eq("mrst_out1", out1, 16'h0);
        for (int i = 1; i <= 7; i++) begin
            run(24'h0, 1'b1, 1'b1);
            check_eq("mrst_out1", out1, 16'h0);
            check_eq("mrst_out2", out2, 16'h0);
            check_eq("mrst_out3", out3, 16'h0);
        end

        // Randomized: random data, random stalls, occasional resets;
        // weights only change on reset edges so they stay stable per stream.
        for (int i = 0; i < 400; i++) begin
            re = ($urandom_range(0, 3) != 0);
            rr = ($urandom_range(0, 39) != 0);
            if (!rr) begin
                rnd96 = {$urandom(), $urandom(), $urandom()};
                w     = rnd96[71:0];
            end
            rnd32 = $urandom();
            run(rnd32[23:0], re, rr);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
